sum_engine: RTL
===============

Name: sum_engine

Overview:
- Self-contained accumulate-loop engine: on request, computes the sum 0 + step + 2·step + … over every term ≤ limit, at one term per clock.
- Integrates its own control FSM. The caller sees only a start pulse in and a valid/ready result out.
- `limit`, `step` and datapath width are programmable.
- Sits between a control/host register block and the output port register stage.

Parameters:
- WIDTH, 8: width of `limit`, `step`, `result` and the internal sum register. The index counter is WIDTH+1 bits.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request; sampled only in S_IDLE
- limit  input  WIDTH  last allowed term value (inclusive); captured when start is accepted
- step  input  WIDTH  term increment; captured when start is accepted; 0 is treated as 1
- busy  output  1  high in every state except S_IDLE
- out_valid  output  1  result available; held until accepted
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  final sum
- overflow  output  1  the sum exceeded 2^WIDTH−1 during the run; qualified by out_valid
- done  output  1  one-cycle pulse in the cycle after the result handshake

Behaviour:
- Reset values: busy=0, out_valid=0, result=0, overflow=0, done=0, state=S_IDLE, sum=0, i=0, limit_q=0, step_q=1.
- States: S_IDLE, S_INIT, S_LOOP, S_OUT.
- S_IDLE:
  - If start=1: limit_q←limit, step_q←(step==0 ? 1 : step), go to S_INIT.
  - Otherwise stay.
- S_INIT: sum←0, i←0, ovf_acc←0, go to S_LOOP.
- S_LOOP, evaluated each cycle:
  - If i ≤ limit_q (unsigned, i zero-extended compare): sum←sum+i[WIDTH-1:0], i←i+step_q, and ovf_acc←1 if the add carried out.
  - Otherwise: result←sum, overflow←ovf_acc, out_valid←1, go to S_OUT.
- Index wrap: i is WIDTH+1 bits, so `limit`=2^WIDTH−1 terminates correctly and never wraps.
- S_OUT:
  - out_valid stays high and result/overflow stay stable until out_ready=1.
  - On the handshake edge: out_valid←0, done←1 for exactly one cycle, go to S_IDLE.
- Latency: with N = floor(limit/step)+1 terms, out_valid rises on the (N+2)th rising edge after the edge that samples start. Example: limit=10, step=1 gives 13 edges.
- Throughput: next start is accepted no earlier than the cycle after the handshake. A start while busy, including in the handshake cycle itself, is ignored (not queued).
- out_ready held high before the result: the handshake completes in the first cycle out_valid is high.
- result/overflow keep their value after the handshake until the next S_LOOP exit.
- Sum arithmetic wraps modulo 2^WIDTH (default build).
- Changing limit/step mid-run has no effect; the captured copies are used.
- Reset mid-operation: immediate return to S_IDLE with all outputs at reset values. No done pulse and no partial result.

Optional Feature:
- Macro SUM_ENGINE_SATURATE_EN.
- Defined: any add that would carry out clamps sum to 2^WIDTH−1. The sum stays clamped for the rest of the run, and overflow is still reported as 1.
- Undefined: modulo-2^WIDTH wrap, with overflow reported as 1.
- Latency and handshake are identical in both builds.

Decomposition:
- Package sum_engine_pkg:
  - state_t enum {S_IDLE, S_INIT, S_LOOP, S_OUT}
  - localparam DEFAULT_WIDTH=8
- Sub-module sum_engine_dp (datapath):
  - holds the sum/i/limit_q/step_q registers, adder, ≤ comparator, and the result/overflow output registers
  - exports i_le_limit and carry
- Top level holds the FSM and drives the datapath's load/enable selects.

Test Plan:
- WIDTH=8, limit=10, step=1, out_ready=1 → result=55, overflow=0, out_valid 13 edges after start, done pulses one cycle later.
- limit=10, step=3 → terms 0,3,6,9 → result=18. step=0, limit=4 → treated as step 1 → result=10.
- limit=22 → 253, overflow=0. limit=23 → wrap build: result=20, overflow=1; saturate build: result=255, overflow=1.
- limit=0 → result=0 after 3 edges. limit=255, step=255 → terms 0,255 → result=255, terminates without index wrap.
- Hold out_ready=0 for 5 cycles, then pulse it → result stable and out_valid high throughout. Starts during busy and in the handshake cycle are ignored; a start one cycle after done is accepted.
- Assert reset mid-S_LOOP → all outputs 0 next cycle, no done pulse. A following start with limit=10 → 55 with normal latency.

Source files
------------

// File: rtl/sum_engine_pkg.sv
// Shared types and defaults for the sum_engine accumulate-loop block.
// Build option: SUM_ENGINE_SATURATE_EN selects a saturating sum instead of a modulo wrap.
package sum_engine_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_LOOP = 2'd2,
    S_OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/sum_engine_if.sv
// Host-facing request/result bundle of sum_engine: a start pulse in, and a
// result with a valid/ready handshake out.
interface sum_engine_if
  import sum_engine_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] step;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             done;

  modport master (
    output start, limit, step, out_ready,
    input  busy, out_valid, result, overflow, done
  );

  modport slave (
    input  start, limit, step, out_ready,
    output busy, out_valid, result, overflow, done
  );

endinterface

// File: rtl/sum_engine_dp.sv
// Datapath of sum_engine: captured operands, running sum and index, and the
// result/overflow registers. Saturates when SUM_ENGINE_SATURATE_EN is defined.
module sum_engine_dp
  import sum_engine_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic             init,
  input  logic             accum,
  input  logic             ovf_set,
  input  logic             latch_out,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] step,
  output logic             i_le_limit,
  output logic             carry,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   i;
  logic             ovf_acc;
  logic [WIDTH:0]   add_full;

  // The index is one bit wider than limit so the step past an all-ones limit
  // lands above it instead of wrapping back to a small value.
  assign add_full   = {1'b0, sum} + {1'b0, i[WIDTH-1:0]};
  assign carry      = add_full[WIDTH];
  assign i_le_limit = (i <= {1'b0, limit_q});

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      limit_q  <= '0;
      step_q   <= WIDTH'(1);
      sum      <= '0;
      i        <= '0;
      ovf_acc  <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      if (capture) begin
        limit_q <= limit;
        step_q  <= (step == '0) ? WIDTH'(1) : step;
      end
      if (init) begin
        sum     <= '0;
        i       <= '0;
        ovf_acc <= 1'b0;
      end else if (accum) begin
`ifdef SUM_ENGINE_SATURATE_EN
        sum <= carry ? '1 : add_full[WIDTH-1:0];
`else
        sum <= add_full[WIDTH-1:0];
`endif
        i <= i + {1'b0, step_q};
        if (ovf_set) ovf_acc <= 1'b1;
      end
      if (latch_out) begin
        result   <= sum;
        overflow <= ovf_acc;
      end
    end
  end

endmodule

// File: rtl/sum_engine.sv
// sum_engine top: control FSM around sum_engine_dp, summing 0, step, 2*step, ...
// up to limit at one term per clock. SUM_ENGINE_SATURATE_EN selects saturation.
module sum_engine
  import sum_engine_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  sum_engine_if.slave   bus
);

  state_t state;
  logic   out_valid_q;
  logic   done_q;
  logic   i_le_limit;
  logic   carry;
  logic   capture;
  logic   init;
  logic   accum;
  logic   latch_out;

  assign capture   = (state == S_IDLE) && bus.start;
  assign init      = (state == S_INIT);
  assign accum     = (state == S_LOOP) && i_le_limit;
  assign latch_out = (state == S_LOOP) && !i_le_limit;

  sum_engine_dp #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .reset      (reset),
    .capture    (capture),
    .init       (init),
    .accum      (accum),
    .ovf_set    (accum && carry),
    .latch_out  (latch_out),
    .limit      (bus.limit),
    .step       (bus.step),
    .i_le_limit (i_le_limit),
    .carry      (carry),
    .result     (bus.result),
    .overflow   (bus.overflow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) state <= S_INIT;
        S_INIT: state <= S_LOOP;
        S_LOOP: begin
          if (!i_le_limit) begin
            out_valid_q <= 1'b1;
            state       <= S_OUT;
          end
        end
        S_OUT: begin
          // A start seen here is dropped: the engine only listens in S_IDLE.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;

endmodule
